// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, register-file write port and forwarding bundle
// shared between the two requesters, decode and the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              writeBack;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              fwd_a_hit;
  logic [DATA_W-1:0] fwd_a_data;
  logic              fwd_b_hit;
  logic [DATA_W-1:0] fwd_b_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output rs, rt,
    input  alu_ready, mem_ready,
    input  writeBack, rd, din,
    input  fwd_a_hit, fwd_a_data,
    input  fwd_b_hit, fwd_b_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  rs, rt,
    output alu_ready, mem_ready,
    output writeBack, rd, din,
    output fwd_a_hit, fwd_a_data,
    output fwd_b_hit, fwd_b_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback,
// ALU-first with a starvation override, plus in-flight write forwarding.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus
);
  localparam int CW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wb_q, wb_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] din_q, din_d;

  logic              grant_mem;
  logic              alu_rdy;
  logic              alu_xfer;
  logic              mem_xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    grant_mem = !rst && bus.mem_valid &&
                (!bus.alu_valid || (cnt_q >= LIM));
    alu_rdy   = !rst && !grant_mem;
    alu_xfer  = bus.alu_valid && alu_rdy;
    mem_xfer  = bus.mem_valid && grant_mem;
  end

  assign bus.mem_ready = grant_mem;
  assign bus.alu_ready = alu_rdy;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    unique case (1'b1)
      mem_xfer: begin
        sel_rd   = bus.mem_rd;
        sel_data = bus.mem_data;
      end
      alu_xfer: begin
        sel_rd   = bus.alu_rd;
        sel_data = bus.alu_data;
      end
      default: ;
    endcase
  end

  // r0 writes are accepted but never reach the write port
  always_comb begin
    wb_d  = 1'b0;
    rd_d  = rd_q;
    din_d = din_q;
    if ((alu_xfer || mem_xfer) && (sel_rd != '0)) begin
      wb_d  = 1'b1;
      rd_d  = sel_rd;
      din_d = sel_data;
    end
  end

  always_comb begin
    cnt_d = '0;
    if (bus.mem_valid && !grant_mem)
      cnt_d = (cnt_q >= LIM) ? LIM : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      wb_q  <= 1'b0;
      rd_q  <= '0;
      din_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      wb_q  <= wb_d;
      rd_q  <= rd_d;
      din_q <= din_d;
    end
  end

  assign bus.writeBack = wb_q;
  assign bus.rd        = rd_q;
  assign bus.din       = din_q;

  always_comb begin
    bus.fwd_a_hit  = wb_q && (rd_q == bus.rs) && (bus.rs != '0);
    bus.fwd_b_hit  = wb_q && (rd_q == bus.rt) && (bus.rt != '0);
    bus.fwd_a_data = bus.fwd_a_hit ? din_q : '0;
    bus.fwd_b_data = bus.fwd_b_hit ? din_q : '0;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter.
// Each vector is one clock: readiness/forwarding before the edge, port after.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wb_arbiter #(
    .DATA_W(32),
    .ADDR_W(5),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic        r;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        ea;
    logic        em;
    logic        efa;
    logic [31:0] efad;
    logic        efb;
    logic [31:0] efbd;
    logic        ewb;
    logic [4:0]  erd;
    logic [31:0] edin;
    logic        cd;
  } vec_t;

  vec_t vq[$];
  int   errs = 0;
  int   chks = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(
    logic r, logic av, logic [4:0] ard, logic [31:0] ad,
    logic mv, logic [4:0] mrd, logic [31:0] md,
    logic [4:0] rs, logic [4:0] rt,
    logic ea, logic em,
    logic efa, logic [31:0] efad, logic efb, logic [31:0] efbd,
    logic ewb, logic [4:0] erd, logic [31:0] edin, logic cd);
    vec_t v;
    v.r = r; v.av = av; v.ard = ard; v.ad = ad;
    v.mv = mv; v.mrd = mrd; v.md = md; v.rs = rs; v.rt = rt;
    v.ea = ea; v.em = em;
    v.efa = efa; v.efad = efad; v.efb = efb; v.efbd = efbd;
    v.ewb = ewb; v.erd = erd; v.edin = edin; v.cd = cd;
    vq.push_back(v);
  endtask

  task automatic drive(logic r, logic av, logic [4:0] ard,
    logic [31:0] ad, logic mv, logic [4:0] mrd, logic [31:0] md,
    logic [4:0] rs, logic [4:0] rt);
    rst           = r;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_rd    = mrd;
    bus.mem_data  = md;
    bus.rs        = rs;
    bus.rt        = rt;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);

    // reset holds everything off even with both requesting
    add(1,1,1,1,    1,3,5,   0,0, 0,0, 0,0,0,0,    0,0,0,1);
    add(1,1,1,1,    1,3,5,   0,0, 0,0, 0,0,0,0,    0,0,0,1);
    // single ALU write, then forward it on rs
    add(0,1,1,2001, 0,0,0,   0,0, 1,0, 0,0,0,0,    1,1,2001,1);
    add(0,0,0,0,    0,0,0,   1,0, 1,0, 1,2001,0,0, 0,1,2001,1);
    // contention: ALU four grants, then forced mem grant
    add(0,1,2,4001, 1,6,8002, 0,0, 1,0, 0,0,0,0,   1,2,4001,1);
    add(0,1,2,4002, 1,6,8002, 2,0, 1,0, 1,4001,0,0,1,2,4002,1);
    add(0,1,2,4003, 1,6,8002, 0,0, 1,0, 0,0,0,0,   1,2,4003,1);
    add(0,1,2,4004, 1,6,8002, 0,0, 1,0, 0,0,0,0,   1,2,4004,1);
    add(0,1,2,4005, 1,6,8002, 0,0, 0,1, 0,0,0,0,   1,6,8002,1);
    add(0,1,2,4005, 0,0,0,   0,6, 1,0, 0,0,1,8002, 1,2,4005,1);
    add(0,1,2,4006, 0,0,0,   0,0, 1,0, 0,0,0,0,    1,2,4006,1);
    add(0,0,0,0,    0,0,0,   0,0, 1,0, 0,0,0,0,    0,2,4006,1);
    // load to r0 is accepted but never written
    add(0,0,0,0,    1,0,3002, 0,0, 0,1, 0,0,0,0,   0,0,0,0);
    // forwarding on rs, then rs=0 vs rt
    add(0,1,8,3002, 0,0,0,   0,0, 1,0, 0,0,0,0,    1,8,3002,1);
    add(0,0,0,0,    0,0,0,   8,1, 1,0, 1,3002,0,0, 0,8,3002,1);
    add(0,1,8,3003, 0,0,0,   0,0, 1,0, 0,0,0,0,    1,8,3003,1);
    add(0,0,0,0,    0,0,0,   0,8, 1,0, 0,0,1,3003, 0,8,3003,1);
    // build up starvation, then reset mid-operation
    add(0,1,9,11,   1,7,777, 0,0, 1,0, 0,0,0,0,    1,9,11,1);
    add(0,1,9,12,   1,7,777, 0,0, 1,0, 0,0,0,0,    1,9,12,1);
    add(0,1,9,13,   1,7,777, 0,0, 1,0, 0,0,0,0,    1,9,13,1);
    add(1,1,6,8002, 1,7,777, 0,0, 0,0, 0,0,0,0,    0,0,0,1);
    add(0,1,6,8002, 1,7,777, 0,0, 1,0, 0,0,0,0,    1,6,8002,1);
    add(0,1,6,8003, 1,7,777, 0,0, 1,0, 0,0,0,0,    1,6,8003,1);
    add(0,0,0,0,    0,0,0,   0,0, 1,0, 0,0,0,0,    0,6,8003,1);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].r, vq[i].av, vq[i].ard, vq[i].ad,
            vq[i].mv, vq[i].mrd, vq[i].md, vq[i].rs, vq[i].rt);
      #1;
      chk($sformatf("v%0d alu_ready", i), 32'(bus.alu_ready), 32'(vq[i].ea));
      chk($sformatf("v%0d mem_ready", i), 32'(bus.mem_ready), 32'(vq[i].em));
      chk($sformatf("v%0d fwd_a_hit", i), 32'(bus.fwd_a_hit), 32'(vq[i].efa));
      chk($sformatf("v%0d fwd_a_data", i), bus.fwd_a_data, vq[i].efad);
      chk($sformatf("v%0d fwd_b_hit", i), 32'(bus.fwd_b_hit), 32'(vq[i].efb));
      chk($sformatf("v%0d fwd_b_data", i), bus.fwd_b_data, vq[i].efbd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d writeBack", i), 32'(bus.writeBack), 32'(vq[i].ewb));
      if (vq[i].cd) begin
        chk($sformatf("v%0d rd", i), 32'(bus.rd), 32'(vq[i].erd));
        chk($sformatf("v%0d din", i), bus.din, vq[i].edin);
      end
    end

    // a gap in mem_valid restarts the starvation count
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 1, 3, 32'(100 + k), 1, 4, 500, 0, 0);
      #1;
      chk($sformatf("pre%0d alu_ready", k), 32'(bus.alu_ready), 1);
    end
    @(negedge clk);
    drive(0, 1, 3, 103, 0, 0, 0, 0, 0);
    #1;
    chk("gap alu_ready", 32'(bus.alu_ready), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(0, 1, 3, 32'(104 + k), 1, 4, 500, 0, 0);
      #1;
      chk($sformatf("post%0d mem_ready", k), 32'(bus.mem_ready),
          (k == 4) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    chk("forced writeBack", 32'(bus.writeBack), 1);
    chk("forced rd", 32'(bus.rd), 4);
    chk("forced din", bus.din, 500);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("idle writeBack", 32'(bus.writeBack), 0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
